// File: rtl/shift_unit_seq.sv
// Multicycle shift unit: one bit position per clock, start/done handshake.
// Define SHIFT_ROTATE_EN to build ROR/ROL; otherwise those codes act as NOP.
module shift_unit_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         ShiftOp,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
`ifdef SHIFT_ROTATE_EN
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
`endif

  state_t             state, state_nx;
  logic [WIDTH-1:0]   sreg, sreg_step;
  logic [SHAMT_W-1:0] count;
  logic [2:0]         op;

  // Single-position step of the working register; unlisted codes hold.
  always_comb begin
    sreg_step = sreg;
    case (op)
      OP_SLL:  sreg_step = {sreg[WIDTH-2:0], 1'b0};
      OP_SRL:  sreg_step = {1'b0, sreg[WIDTH-1:1]};
      OP_SRA:  sreg_step = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROR:  sreg_step = {sreg[0], sreg[WIDTH-1:1]};
      OP_ROL:  sreg_step = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
`endif
      default: sreg_step = sreg;
    endcase
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (count == '0) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sreg   <= '0;
      count  <= '0;
      op     <= OP_NOP;
      result <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          sreg  <= data_in;
          count <= shamt;
          op    <= ShiftOp;
        end
        SHIFT: begin
          // result only moves on the final transition so it never shows partial shifts
          if (count != '0) begin
            sreg  <= sreg_step;
            count <= count - SHAMT_W'(1);
          end else begin
            result <= sreg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: vector table, corner sequences, random ops.
// Expectations follow the SHIFT_ROTATE_EN setting of the build.
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  ShiftOp;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_res;

  shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .ShiftOp(ShiftOp),
    .data_in(data_in), .shamt(shamt), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] d;
    logic [4:0]  n;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Whole-amount reference: shifting by n at once equals n single-bit steps.
  function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] d,
                                            input int n);
    logic [31:0] r;
    case (op)
      3'd1: r = d << n;
      3'd2: r = d >> n;
      3'd3: r = $unsigned($signed(d) >>> n);
      3'd4: r = ROT ? ((d >> n) | (d << (32 - n))) : d;
      3'd5: r = ROT ? ((d << n) | (d >> (32 - n))) : d;
      default: r = d;
    endcase
    return r;
  endfunction

  // Issues one start and watches n+5 cycles, sampled 1 time unit after each edge.
  // Observation index c is the cycle after edge c of the accepting edge, so done
  // seen at c=n+1 is the one sampled by edge n+2.
  task automatic run_op(input logic [2:0] op, input logic [31:0] d, input logic [4:0] n,
                        input logic [31:0] exp, input int inject_at, input string name);
    int done_c, ndone, busy_c;
    bit held_ok;
    logic [31:0] got, r;
    ShiftOp = op; data_in = d; shamt = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r = $urandom; ShiftOp = r[2:0]; shamt = r[7:3]; data_in = $urandom;
    done_c = -1; ndone = 0; busy_c = 0; held_ok = 1'b1; got = 'x;
    for (int c = 0; c < int'(n) + 5; c++) begin
      if (busy) busy_c++;
      if (done) begin
        ndone++;
        if (done_c < 0) begin done_c = c; got = result; end
      end else if (done_c < 0 && result !== model_res) held_ok = 1'b0;
      if (c == inject_at) begin
        start = 1'b1; data_in = ~d; ShiftOp = 3'b001; shamt = 5'd1;
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({name, " result"}, got, exp);
    chk({name, " done_cycle"}, done_c, int'(n) + 1);
    chk({name, " done_count"}, ndone, 1);
    chk({name, " busy_cycles"}, busy_c, int'(n) + 2);
    chk({name, " result_held"}, {31'd0, held_ok}, 32'd1);
    model_res = exp;
  endtask

  vec_t vecs[11];

  initial begin
    logic [31:0] r, d;
    logic [2:0] op;
    logic [4:0] n;

    vecs[0]  = '{3'd1, 32'h0000_0001, 5'd4,  32'h0000_0010};
    vecs[1]  = '{3'd3, 32'hF000_0000, 5'd4,  32'hFF00_0000};
    vecs[2]  = '{3'd2, 32'hF000_0000, 5'd4,  32'h0F00_0000};
    vecs[3]  = '{3'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4]  = '{3'd3, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[5]  = '{3'd1, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[6]  = '{3'd4, 32'h0000_0001, 5'd1,  ROT ? 32'h8000_0000 : 32'h0000_0001};
    vecs[7]  = '{3'd5, 32'h8000_0001, 5'd2,  ROT ? 32'h0000_0006 : 32'h8000_0001};
    vecs[8]  = '{3'd6, 32'h1234_5678, 5'd3,  32'h1234_5678};
    vecs[9]  = '{3'd7, 32'hCAFE_F00D, 5'd5,  32'hCAFE_F00D};
    vecs[10] = '{3'd0, 32'hA5A5_A5A5, 5'd7,  32'hA5A5_A5A5};

    reset = 1'b1; start = 1'b0; ShiftOp = 3'd0; data_in = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    model_res = 32'd0;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].d, vecs[i].n, vecs[i].exp, -1, $sformatf("vec%0d", i));

    // Second start two cycles into an 8-step shift must be dropped.
    run_op(3'd1, 32'h0000_0003, 5'd8, 32'h0000_0300, 2, "busy_start");

    // Reset mid-shift: reset is sampled by the 5th edge after the accepting edge.
    ShiftOp = 3'd1; data_in = 32'h0000_0001; shamt = 5'd20; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort pre done%0d", k), {31'd0, done}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort result", result, 32'd0);
    model_res = 32'd0;
    begin
      int seen = 0;
      for (int k = 0; k < 25; k++) begin
        if (done || busy) seen++;
        @(posedge clk); #1;
      end
      chk("abort no_done", seen, 0);
    end
    run_op(3'd1, 32'h0000_0001, 5'd20, 32'h0010_0000, -1, "after_abort");

    for (int i = 0; i < 40; i++) begin
      r = $urandom; op = r[2:0]; n = r[7:3]; d = $urandom;
      run_op(op, d, n, ref_shift(op, d, int'(n)), -1, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
